spm_arbiter: RTL and testbench

Two-port arbiter that shares one 256-byte, 4-lane byte-enabled scratchpad (64 x 32-bit words) between two requesters, e.g. the core data port (port 0) and a DMA/network port (port 1).
- Accepts at most one command per cycle and drives the scratchpad directly.
- Returns a registered one-cycle response.
- Round-robin with a bounded run length, so a streaming requester cannot starve the other.

---
 rtl/spm_arbiter.sv | 98 +++++++++
 tb/tb_spm_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spm_arbiter.sv
// Two-port round-robin arbiter in front of a 64x32 byte-enabled scratchpad.
// One command per cycle, registered single-cycle response, bounded run length under contention.
module spm_arbiter #(
  parameter int unsigned MAX_RUN = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  io_m0_Cmd,
  input  logic [7:0]  io_m0_Addr,
  input  logic [31:0] io_m0_Data,
  input  logic [3:0]  io_m0_ByteEn,
  output logic        io_s0_CmdAccept,
  output logic [1:0]  io_s0_Resp,
  output logic [31:0] io_s0_Data,
  input  logic [1:0]  io_m1_Cmd,
  input  logic [7:0]  io_m1_Addr,
  input  logic [31:0] io_m1_Data,
  input  logic [3:0]  io_m1_ByteEn,
  output logic        io_s1_CmdAccept,
  output logic [1:0]  io_s1_Resp,
  output logic [31:0] io_s1_Data,
  output logic [7:0]  io_spm_M_Addr,
  output logic [31:0] io_spm_M_Data,
  output logic [3:0]  io_spm_M_ByteEn,
  output logic        io_spm_M_We,
  input  logic [31:0] io_spm_S_Data
);
  localparam logic [1:0] CMD_WR    = 2'b01;
  localparam logic [1:0] CMD_RD    = 2'b10;
  localparam logic [1:0] RESP_NULL = 2'b00;
  localparam logic [1:0] RESP_DVA  = 2'b01;
  localparam logic [3:0] RUN_LIM   = 4'(MAX_RUN);

  logic        owner;
  logic [3:0]  run_cnt;
  logic        resp_valid;
  logic        resp_port;
  logic [31:0] resp_data;

  logic        req0, req1, gnt, gnt_port;
  logic [1:0]  g_cmd;
  logic [7:0]  g_addr;
  logic [31:0] g_data;
  logic [3:0]  g_be;

  always_comb begin
    req0     = (io_m0_Cmd == CMD_WR) || (io_m0_Cmd == CMD_RD);
    req1     = (io_m1_Cmd == CMD_WR) || (io_m1_Cmd == CMD_RD);
    gnt      = (req0 || req1) && !reset;
    // Tie goes to the owner until it has used up its run, then flips.
    if (req0 && req1) gnt_port = (run_cnt < RUN_LIM) ? owner : ~owner;
    else              gnt_port = req1;
    g_cmd  = gnt_port ? io_m1_Cmd    : io_m0_Cmd;
    g_addr = gnt_port ? io_m1_Addr   : io_m0_Addr;
    g_data = gnt_port ? io_m1_Data   : io_m0_Data;
    g_be   = gnt_port ? io_m1_ByteEn : io_m0_ByteEn;
  end

  assign io_s0_CmdAccept = gnt && !gnt_port;
  assign io_s1_CmdAccept = gnt &&  gnt_port;

  assign io_spm_M_Addr   = gnt ? g_addr : '0;
  assign io_spm_M_Data   = gnt ? g_data : '0;
  assign io_spm_M_ByteEn = gnt ? g_be   : '0;
  assign io_spm_M_We     = gnt && (g_cmd == CMD_WR);

  // Gating with reset drops a response that was in flight when reset arrived.
  logic rsp0, rsp1;
  assign rsp0 = resp_valid && !reset && !resp_port;
  assign rsp1 = resp_valid && !reset &&  resp_port;

  assign io_s0_Resp = rsp0 ? RESP_DVA : RESP_NULL;
  assign io_s1_Resp = rsp1 ? RESP_DVA : RESP_NULL;
  assign io_s0_Data = rsp0 ? resp_data : '0;
  assign io_s1_Data = rsp1 ? resp_data : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      owner      <= 1'b0;
      run_cnt    <= '0;
      resp_valid <= 1'b0;
      resp_port  <= 1'b0;
      resp_data  <= '0;
    end else begin
      resp_valid <= gnt;
      resp_port  <= gnt_port;
      resp_data  <= (gnt && g_cmd == CMD_RD) ? io_spm_S_Data : '0;
      if (!gnt) begin
        run_cnt <= '0;
      end else if (gnt_port == owner) begin
        run_cnt <= (run_cnt == 4'hf) ? run_cnt : run_cnt + 4'd1;
      end else begin
        owner   <= gnt_port;
        run_cnt <= 4'd1;
      end
    end
  end
endmodule

// File: tb/tb_spm_arbiter.sv
// Bench for spm_arbiter: scratchpad stand-in plus a transaction-level reference model
// (grant rule, expected responses and an independent copy of memory contents).
module tb_spm_arbiter;
  localparam int MAX_RUN = 4;
  localparam logic [1:0] IDLE = 2'b00, WR = 2'b01, RD = 2'b10;

  typedef struct packed {
    logic [1:0]  cmd;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  be;
  } req_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  req_t r0 = '0, r1 = '0;

  logic        acc0, acc1, we;
  logic [1:0]  resp0, resp1;
  logic [31:0] d0, d1, spm_wdata, spm_rd;
  logic [7:0]  spm_addr;
  logic [3:0]  spm_be;

  always #5 clk = ~clk;

  spm_arbiter #(.MAX_RUN(MAX_RUN)) dut (
    .clk(clk), .reset(rst),
    .io_m0_Cmd(r0.cmd), .io_m0_Addr(r0.addr), .io_m0_Data(r0.data), .io_m0_ByteEn(r0.be),
    .io_s0_CmdAccept(acc0), .io_s0_Resp(resp0), .io_s0_Data(d0),
    .io_m1_Cmd(r1.cmd), .io_m1_Addr(r1.addr), .io_m1_Data(r1.data), .io_m1_ByteEn(r1.be),
    .io_s1_CmdAccept(acc1), .io_s1_Resp(resp1), .io_s1_Data(d1),
    .io_spm_M_Addr(spm_addr), .io_spm_M_Data(spm_wdata), .io_spm_M_ByteEn(spm_be),
    .io_spm_M_We(we), .io_spm_S_Data(spm_rd)
  );

  // Scratchpad stand-in: combinational read, lane-masked write on the clock edge.
  logic [31:0] spm [64] = '{default: '0};
  assign spm_rd = spm[spm_addr[7:2]];
  always @(posedge clk)
    if (we)
      for (int i = 0; i < 4; i++)
        if (spm_be[i]) spm[spm_addr[7:2]][8*i +: 8] <= spm_wdata[8*i +: 8];

  wire [69:0] obs_rsp = {acc0, acc1, resp0, resp1, d0, d1};
  wire [44:0] obs_spm = {we, spm_addr, spm_wdata, spm_be};

  // Reference model state
  int          last = 0, streak = 0, g = -1;
  bit          pv = 0;
  int          pp = 0;
  logic [31:0] pd = '0;
  logic [31:0] ref_mem [64] = '{default: '0};
  logic [69:0] e_rsp;
  logic [44:0] e_spm, e_msk;
  int err = 0, chk = 0;

  function automatic bit is_req(req_t r);
    return (r.cmd == WR) || (r.cmd == RD);
  endfunction

  function automatic req_t mk(logic [1:0] c, logic [7:0] a, logic [31:0] d, logic [3:0] b);
    req_t r;
    r.cmd = c; r.addr = a; r.data = d; r.be = b;
    return r;
  endfunction

  function automatic req_t rnd(logic [1:0] c);
    return mk(c, 8'($urandom), $urandom, 4'($urandom));
  endfunction

  task automatic eval_model();
    req_t r;
    bit q0, q1;
    q0 = is_req(r0);
    q1 = is_req(r1);
    if (rst || !(q0 || q1)) g = -1;
    else if (q0 && q1)      g = (streak < MAX_RUN) ? last : 1 - last;
    else                    g = q0 ? 0 : 1;
    e_rsp = '0;
    e_rsp[69] = (g == 0);
    e_rsp[68] = (g == 1);
    if (pv && !rst) begin
      if (pp == 0) begin e_rsp[67:66] = 2'b01; e_rsp[63:32] = pd; end
      else         begin e_rsp[65:64] = 2'b01; e_rsp[31:0]  = pd; end
    end
    e_spm = '0;
    e_msk = '1;
    if (g >= 0) begin
      r = (g == 1) ? r1 : r0;
      e_spm = {(r.cmd == WR), r.addr, r.data, r.be};
      if (r.cmd == RD) e_msk[3:0] = '0;
    end
  endtask

  task automatic commit_model();
    req_t r;
    if (rst) begin
      pv = 0; pp = 0; pd = '0; last = 0; streak = 0;
    end else if (g < 0) begin
      pv = 0; streak = 0;
    end else begin
      r = (g == 1) ? r1 : r0;
      pv = 1; pp = g;
      if (r.cmd == RD) pd = ref_mem[r.addr[7:2]];
      else begin
        pd = '0;
        for (int i = 0; i < 4; i++)
          if (r.be[i]) ref_mem[r.addr[7:2]][8*i +: 8] = r.data[8*i +: 8];
      end
      if (g == last) streak = (streak < 15) ? streak + 1 : 15;
      else begin last = g; streak = 1; end
    end
  endtask

  task automatic settle();
    @(negedge clk);
    eval_model();
  endtask

  task automatic advance();
    commit_model();
    @(posedge clk);
    #1;
  endtask

  // Runs until every held request is served and the last response has shown.
  task automatic drain(input string nm);
    int k;
    for (k = 0; k < 12 && (is_req(r0) || is_req(r1) || pv); k++) begin
      settle();
      chk++; if (obs_rsp !== e_rsp) begin err++; $display("FAIL %s_drain rsp cyc %0d: got %h exp %h", nm, k, obs_rsp, e_rsp); end
      chk++; if ((obs_spm & e_msk) !== (e_spm & e_msk)) begin err++; $display("FAIL %s_drain spm cyc %0d: got %h exp %h", nm, k, obs_spm, e_spm); end
      advance();
      if (g == 0) r0 = '0;
      if (g == 1) r1 = '0;
    end
    chk++; if (k >= 12) begin err++; $display("FAIL %s_drain bound: got pending exp idle", nm); end
  endtask

  task automatic test_reset();
    r0 = rnd(RD);
    r1 = rnd(WR);
    for (int k = 0; k < 2; k++) begin
      settle();
      chk++; if (obs_rsp !== e_rsp) begin err++; $display("FAIL reset rsp cyc %0d: got %h exp %h", k, obs_rsp, e_rsp); end
      chk++; if (obs_spm !== 45'd0) begin err++; $display("FAIL reset spm cyc %0d: got %h exp 0", k, obs_spm); end
      advance();
    end
    rst = 1'b0;
    r0 = '0;
    r1 = '0;
    settle();
    chk++; if (obs_rsp !== 70'd0) begin err++; $display("FAIL reset_after rsp: got %h exp 0", obs_rsp); end
    chk++; if (obs_spm !== 45'd0) begin err++; $display("FAIL reset_after spm: got %h exp 0", obs_spm); end
    advance();
  endtask

  // Write then read of the same word on consecutive cycles, with fixed expected values.
  task automatic test_port_seq(input string nm, input int p, input req_t a, input req_t b,
                               input logic [31:0] rd_exp);
    logic [34:0] want [3];
    logic [34:0] got;
    want[0] = {1'b1, 2'b00, 32'h0};
    want[1] = {1'b1, 2'b01, 32'h0};
    want[2] = {1'b0, 2'b01, rd_exp};
    if (p == 0) r0 = a; else r1 = a;
    for (int k = 0; k < 3; k++) begin
      settle();
      got = (p == 0) ? {acc0, resp0, d0} : {acc1, resp1, d1};
      chk++; if (obs_rsp !== e_rsp) begin err++; $display("FAIL %s rsp cyc %0d: got %h exp %h", nm, k, obs_rsp, e_rsp); end
      chk++; if ((obs_spm & e_msk) !== (e_spm & e_msk)) begin err++; $display("FAIL %s spm cyc %0d: got %h exp %h", nm, k, obs_spm, e_spm); end
      chk++; if (got !== want[k]) begin err++; $display("FAIL %s fixed cyc %0d: got %h exp %h", nm, k, got, want[k]); end
      advance();
      if (p == 0) r0 = (k == 0) ? b : '0;
      else        r1 = (k == 0) ? b : '0;
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] want;
    rst = 1'b1;
    settle();
    advance();
    rst = 1'b0;
    r0 = rnd(RD);
    r1 = rnd(RD);
    for (int k = 0; k < 18; k++) begin
      settle();
      want = ((k / 4) % 2 == 1) ? 2'b01 : 2'b10;
      chk++; if (obs_rsp !== e_rsp) begin err++; $display("FAIL rr rsp cyc %0d: got %h exp %h", k, obs_rsp, e_rsp); end
      chk++; if ((obs_spm & e_msk) !== (e_spm & e_msk)) begin err++; $display("FAIL rr spm cyc %0d: got %h exp %h", k, obs_spm, e_spm); end
      chk++; if ({acc0, acc1} !== want) begin err++; $display("FAIL rr pattern cyc %0d: got %b exp %b", k, {acc0, acc1}, want); end
      advance();
      if (g == 0) r0 = rnd(RD);
      if (g == 1) r1 = rnd(RD);
    end
    drain("rr");
  endtask

  task automatic test_starvation();
    int w0 = 0, w1 = 0, wmax = 0;
    r1 = rnd(RD);
    for (int k = 0; k < 10; k++) begin
      settle();
      chk++; if (obs_rsp !== e_rsp) begin err++; $display("FAIL starve rsp cyc %0d: got %h exp %h", k, obs_rsp, e_rsp); end
      chk++; if ({acc0, acc1} !== 2'b01) begin err++; $display("FAIL starve solo cyc %0d: got %b exp 01", k, {acc0, acc1}); end
      advance();
      r1 = rnd(RD);
    end
    r0 = rnd(RD);
    settle();
    chk++; if ({acc0, acc1} !== 2'b10) begin err++; $display("FAIL starve join: got %b exp 10", {acc0, acc1}); end
    chk++; if (obs_rsp !== e_rsp) begin err++; $display("FAIL starve join rsp: got %h exp %h", obs_rsp, e_rsp); end
    advance();
    if (g == 0) r0 = rnd(RD);
    for (int k = 0; k < 12; k++) begin
      settle();
      w0 = acc0 ? 0 : w0 + 1;
      w1 = acc1 ? 0 : w1 + 1;
      if (w0 > wmax) wmax = w0;
      if (w1 > wmax) wmax = w1;
      chk++; if (obs_rsp !== e_rsp) begin err++; $display("FAIL starve both rsp cyc %0d: got %h exp %h", k, obs_rsp, e_rsp); end
      advance();
      if (g == 0) r0 = rnd(RD);
      if (g == 1) r1 = rnd(RD);
    end
    chk++; if (wmax > MAX_RUN) begin err++; $display("FAIL starve wait: got %0d exp <= %0d", wmax, MAX_RUN); end
    drain("starve");
  endtask

  task automatic test_tie_after_idle();
    r1 = rnd(RD);
    drain("tie_pre");
    settle();
    chk++; if (obs_rsp !== 70'd0) begin err++; $display("FAIL tie idle: got %h exp 0", obs_rsp); end
    advance();
    r0 = rnd(RD);
    r1 = rnd(RD);
    settle();
    chk++; if ({acc0, acc1} !== 2'b01) begin err++; $display("FAIL tie owner: got %b exp 01", {acc0, acc1}); end
    chk++; if (obs_rsp !== e_rsp) begin err++; $display("FAIL tie rsp: got %h exp %h", obs_rsp, e_rsp); end
    advance();
    if (g == 0) r0 = '0;
    if (g == 1) r1 = '0;
    drain("tie");
  endtask

  task automatic test_reset_mid();
    r0 = rnd(RD);
    settle();
    chk++; if (acc0 !== 1'b1) begin err++; $display("FAIL rstmid accept N: got %b exp 1", acc0); end
    advance();
    rst = 1'b1;
    r0 = '0;
    r1 = rnd(WR);
    settle();
    chk++; if ({acc0, acc1, resp0, resp1, we} !== 7'd0) begin err++; $display("FAIL rstmid N+1: got %b exp 0", {acc0, acc1, resp0, resp1, we}); end
    chk++; if (obs_rsp !== e_rsp) begin err++; $display("FAIL rstmid N+1 rsp: got %h exp %h", obs_rsp, e_rsp); end
    advance();
    rst = 1'b0;
    settle();
    chk++; if ({acc0, acc1, resp0, resp1} !== 6'b010000) begin err++; $display("FAIL rstmid N+2: got %b exp 010000", {acc0, acc1, resp0, resp1}); end
    chk++; if ((obs_spm & e_msk) !== (e_spm & e_msk)) begin err++; $display("FAIL rstmid N+2 spm: got %h exp %h", obs_spm, e_spm); end
    advance();
    r1 = '0;
    settle();
    chk++; if ({resp1, d1} !== {2'b01, 32'h0}) begin err++; $display("FAIL rstmid N+3: got %h exp 100000000", {resp1, d1}); end
    advance();
  endtask

  task automatic test_random();
    for (int k = 0; k < 80; k++) begin
      settle();
      chk++; if (obs_rsp !== e_rsp) begin err++; $display("FAIL rand rsp cyc %0d: got %h exp %h", k, obs_rsp, e_rsp); end
      chk++; if ((obs_spm & e_msk) !== (e_spm & e_msk)) begin err++; $display("FAIL rand spm cyc %0d: got %h exp %h", k, obs_spm, e_spm); end
      advance();
      if (!is_req(r0) || g == 0) r0 = rnd(2'($urandom));
      if (!is_req(r1) || g == 1) r1 = rnd(2'($urandom));
    end
    drain("rand");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_port_seq("basic", 0, mk(WR, 8'h10, 32'hDEADBEEF, 4'hF), mk(RD, 8'h10, 32'h0, 4'h0), 32'hDEADBEEF);
    test_port_seq("partial", 1, mk(WR, 8'h12, 32'h00AA5500, 4'h6), mk(RD, 8'h10, 32'h0, 4'h0), 32'hDEAA55EF);
    test_port_seq("zero_be", 0, mk(WR, 8'h11, 32'hFFFFFFFF, 4'h0), mk(RD, 8'h10, 32'h0, 4'hF), 32'hDEAA55EF);
    test_round_robin();
    test_starvation();
    test_tie_after_idle();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", err, chk);
    $finish;
  end
endmodule
